// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_redirect_unit_pkg
//   Types and constants shared by the fetch/redirect slice.
//   bj_result_t  : branch/jump outcome encoding from execute (2'b10 is reserved)
//   NOP_INSTR    : canonical RV32I NOP (addi x0, x0, 0)
//   INSTR_BYTES  : size of one instruction word in bytes
package fetch_redirect_unit_pkg;

    typedef enum logic [1:0] {
        BJ_NONE   = 2'b00,
        BJ_BRANCH = 2'b01,
        BJ_JALR   = 2'b11
    } bj_result_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

    // Instruction fetches must land on a word boundary.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if
//   Bundles everything the fetch unit exchanges with execute, imem and decode.
//   master : the fetch unit (drives imem request, decode output, flush, misalign)
//   slave  : the surrounding core / memory model
//   Signals:
//     i_B_J_result, i_Branch_Target, i_Jalr_Target : redirect request from execute
//     o_Imem_Req, o_Imem_Addr, i_Imem_Gnt           : imem request channel
//     i_Imem_Rvalid, i_Imem_Rdata                   : imem response channel
//     o_Instr, o_Instr_PC, o_Instr_Valid, i_Instr_Ready : decode handshake
//     o_Flush, o_Misaligned                         : IF/ID flush, bad-target pulse
interface fetch_redirect_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      i_B_J_result;
    logic [XLEN-1:0] i_Branch_Target;
    logic [XLEN-1:0] i_Jalr_Target;

    logic            o_Imem_Req;
    logic [XLEN-1:0] o_Imem_Addr;
    logic            i_Imem_Gnt;
    logic            i_Imem_Rvalid;
    logic [31:0]     i_Imem_Rdata;

    logic [31:0]     o_Instr;
    logic [XLEN-1:0] o_Instr_PC;
    logic            o_Instr_Valid;
    logic            i_Instr_Ready;

    logic            o_Flush;
    logic            o_Misaligned;

    modport master (
        input  i_B_J_result, i_Branch_Target, i_Jalr_Target,
        output o_Imem_Req, o_Imem_Addr,
        input  i_Imem_Gnt, i_Imem_Rvalid, i_Imem_Rdata,
        output o_Instr, o_Instr_PC, o_Instr_Valid,
        input  i_Instr_Ready,
        output o_Flush, o_Misaligned
    );

    modport slave (
        output i_B_J_result, i_Branch_Target, i_Jalr_Target,
        input  o_Imem_Req, o_Imem_Addr,
        output i_Imem_Gnt, i_Imem_Rvalid, i_Imem_Rdata,
        input  o_Instr, o_Instr_PC, o_Instr_Valid,
        output i_Instr_Ready,
        input  o_Flush, o_Misaligned
    );

endinterface

// File: rtl/fetch_redirect_unit_out_reg.sv
// fetch_redirect_unit_out_reg
//   One-entry valid/ready holding register for {instr, pc} at the IF/ID boundary.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture instr_i/pc_i and mark valid
//   clear_i      : drop the held entry (redirect flush); wins over load_i
//   ready_i      : consumer accepts the held entry this cycle
//   valid_o, instr_o, pc_o : held entry
module fetch_redirect_unit_out_reg #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic            ready_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            // A load in the same cycle as a handshake simply replaces the entry.
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit
//   Owns the PC and the single-outstanding imem fetch port. Applies branch/JALR
//   redirects from execute, drops responses that became stale after a redirect and
//   hands fetched words to decode through a one-entry output register.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : fetch_redirect_unit_if master port (execute, imem, decode, flush)
//   Parameters   : XLEN data/address width, RESET_PC first fetch address
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                   i_clk,
    input logic                   i_rst,
    fetch_redirect_unit_if.master bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REQ       = 3'd1;
    localparam logic [2:0] WAIT      = 3'd2;
    localparam logic [2:0] REQ_STALE = 3'd3;
    localparam logic [2:0] DROP      = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    // PC of the request most recently put on the bus (also the held address in REQ_STALE).
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    bj_result_t      bj;
    logic            redirect_req;
    logic [XLEN-1:0] target;
    logic            target_ok;
    logic            do_redirect;
    logic            misaligned;

    logic            slot_free;
    logic            imem_req;
    logic            granted;
    logic            out_load;
    logic            out_valid;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;

    // Reserved 2'b10 falls into the default arm and behaves as BJ_NONE.
    assign bj = bj_result_t'(bus.i_B_J_result);

    always_comb begin
        redirect_req = 1'b0;
        target       = bus.i_Branch_Target;
        case (bj)
            BJ_BRANCH: begin
                redirect_req = 1'b1;
                target       = bus.i_Branch_Target;
            end
            BJ_JALR: begin
                redirect_req = 1'b1;
                target       = {bus.i_Jalr_Target[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    assign target_ok   = is_word_aligned(target[1:0]);
    // Gated by reset so flush/misalign read as idle while the unit is held in reset.
    assign do_redirect = redirect_req && target_ok && !i_rst;
    assign misaligned  = redirect_req && !target_ok && !i_rst;

    // Only fetch when the output register is guaranteed to have room for the result.
    assign slot_free = !out_valid || bus.i_Instr_Ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        imem_req = 1'b0;
        out_load = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = slot_free;
                if (imem_req && bus.i_Imem_Gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(INSTR_BYTES);
                    state_d  = do_redirect ? DROP : WAIT;
                end else if (do_redirect && imem_req) begin
                    // Request is already visible on the bus: keep it stable until granted.
                    req_pc_d = pc_q;
                    state_d  = REQ_STALE;
                end
            end
            REQ_STALE: begin
                imem_req = 1'b1;
                if (bus.i_Imem_Gnt) begin
                    state_d = DROP;
                end
            end
            WAIT: begin
                if (bus.i_Imem_Rvalid) begin
                    out_load = !do_redirect;
                    state_d  = REQ;
                end else if (do_redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.i_Imem_Rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect always wins over the sequential PC increment.
        if (do_redirect) begin
            pc_d = target;
        end
    end

    assign granted = imem_req && bus.i_Imem_Gnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_redirect_unit_out_reg #(
        .XLEN(XLEN)
    ) u_out_reg (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (out_load),
        .clear_i (do_redirect),
        .ready_i (bus.i_Instr_Ready),
        .instr_i (bus.i_Imem_Rdata),
        .pc_i    (req_pc_q),
        .valid_o (out_valid),
        .instr_o (out_instr),
        .pc_o    (out_pc)
    );

    assign bus.o_Imem_Req    = imem_req;
    assign bus.o_Imem_Addr   = (state_q == REQ_STALE) ? req_pc_q : pc_q;
    assign bus.o_Instr       = out_instr;
    assign bus.o_Instr_PC    = out_pc;
    assign bus.o_Instr_Valid = out_valid;
    assign bus.o_Flush       = do_redirect;
    assign bus.o_Misaligned  = misaligned;

    // Execute must never present the reserved encoding.
    assert property (@(posedge i_clk) disable iff (i_rst) bus.i_B_J_result != 2'b10)
        else $error("reserved i_B_J_result encoding 2'b10 seen");

    logic unused_granted;
    assign unused_granted = granted;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit
//   Directed bench for fetch_redirect_unit with RESET_PC = 0x100. The imem model
//   grants in the cycle a request is seen and returns rdata = 0xA000_0000 | addr
//   one cycle after the grant.
module tb_fetch_redirect_unit;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RST_PC = 32'h0000_0100;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_redirect_unit_if #(.XLEN(XLEN)) bus ();

    fetch_redirect_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Starts in REQ: one full grant/response round trip for address a.
    task automatic fetch_one(input logic [31:0] a);
        check("req_on", {31'd0, bus.o_Imem_Req}, 32'd1);
        check("req_addr", bus.o_Imem_Addr, a);
        bus.i_Imem_Gnt = 1'b1;
        tick();
        bus.i_Imem_Gnt = 1'b0;
        check("wait_no_req", {31'd0, bus.o_Imem_Req}, 32'd0);
        bus.i_Imem_Rvalid = 1'b1;
        bus.i_Imem_Rdata  = 32'hA000_0000 | a;
        tick();
        bus.i_Imem_Rvalid = 1'b0;
        check("out_valid", {31'd0, bus.o_Instr_Valid}, 32'd1);
        check("out_pc", bus.o_Instr_PC, a);
        check("out_instr", bus.o_Instr, 32'hA000_0000 | a);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.i_B_J_result    = 2'b00;
        bus.i_Branch_Target = '0;
        bus.i_Jalr_Target   = '0;
        bus.i_Imem_Gnt      = 1'b0;
        bus.i_Imem_Rvalid   = 1'b0;
        bus.i_Imem_Rdata    = '0;
        bus.i_Instr_Ready   = 1'b1;

        // Reset values, with a redirect presented during reset.
        tick();
        tick();
        check("rst_req", {31'd0, bus.o_Imem_Req}, 32'd0);
        check("rst_addr", bus.o_Imem_Addr, RST_PC);
        check("rst_instr", bus.o_Instr, 32'd0);
        check("rst_pc", bus.o_Instr_PC, 32'd0);
        check("rst_valid", {31'd0, bus.o_Instr_Valid}, 32'd0);
        bus.i_B_J_result    = 2'b01;
        bus.i_Branch_Target = 32'h200;
        settle();
        check("rst_flush", {31'd0, bus.o_Flush}, 32'd0);
        bus.i_Branch_Target = 32'h203;
        settle();
        check("rst_misal", {31'd0, bus.o_Misaligned}, 32'd0);
        bus.i_B_J_result = 2'b00;
        rst = 1'b0;
        settle();
        check("idle_req", {31'd0, bus.o_Imem_Req}, 32'd0);
        tick();

        // 1. Sequential stream 0x100, 0x104, 0x108.
        fetch_one(32'h100);
        fetch_one(32'h104);
        fetch_one(32'h108);

        // 2. Branch to 0x200 while in WAIT; that response is dropped.
        bus.i_Imem_Gnt = 1'b1;
        tick();
        bus.i_Imem_Gnt      = 1'b0;
        bus.i_B_J_result    = 2'b01;
        bus.i_Branch_Target = 32'h200;
        settle();
        check("br_flush", {31'd0, bus.o_Flush}, 32'd1);
        check("br_misal", {31'd0, bus.o_Misaligned}, 32'd0);
        tick();
        bus.i_B_J_result = 2'b00;
        settle();
        check("br_flush_end", {31'd0, bus.o_Flush}, 32'd0);
        check("drop_no_req", {31'd0, bus.o_Imem_Req}, 32'd0);
        bus.i_Imem_Rvalid = 1'b1;
        bus.i_Imem_Rdata  = 32'hA000_010C;
        tick();
        bus.i_Imem_Rvalid = 1'b0;
        check("drop_valid", {31'd0, bus.o_Instr_Valid}, 32'd0);
        fetch_one(32'h200);

        // 3a. JALR to 0x301 is redirected to 0x300.
        bus.i_Imem_Gnt = 1'b1;
        tick();
        bus.i_Imem_Gnt    = 1'b0;
        bus.i_B_J_result  = 2'b11;
        bus.i_Jalr_Target = 32'h301;
        settle();
        check("jalr_flush", {31'd0, bus.o_Flush}, 32'd1);
        check("jalr_misal", {31'd0, bus.o_Misaligned}, 32'd0);
        tick();
        bus.i_B_J_result  = 2'b00;
        bus.i_Imem_Rvalid = 1'b1;
        bus.i_Imem_Rdata  = 32'hA000_0204;
        tick();
        bus.i_Imem_Rvalid = 1'b0;
        fetch_one(32'h300);

        // 3b. Misaligned branch to 0x302: pulse only, the stream continues.
        bus.i_Imem_Gnt = 1'b1;
        tick();
        bus.i_Imem_Gnt      = 1'b0;
        bus.i_B_J_result    = 2'b01;
        bus.i_Branch_Target = 32'h302;
        bus.i_Imem_Rvalid   = 1'b1;
        bus.i_Imem_Rdata    = 32'hA000_0304;
        settle();
        check("mis_pulse", {31'd0, bus.o_Misaligned}, 32'd1);
        check("mis_flush", {31'd0, bus.o_Flush}, 32'd0);
        tick();
        bus.i_B_J_result  = 2'b00;
        bus.i_Imem_Rvalid = 1'b0;
        settle();
        check("mis_end", {31'd0, bus.o_Misaligned}, 32'd0);
        check("mis_out_pc", bus.o_Instr_PC, 32'h304);
        fetch_one(32'h308);

        // 4. Redirect to 0x400 in REQ with gnt low for 3 cycles.
        bus.i_B_J_result    = 2'b01;
        bus.i_Branch_Target = 32'h400;
        settle();
        check("stale_flush", {31'd0, bus.o_Flush}, 32'd1);
        check("stale_addr0", bus.o_Imem_Addr, 32'h30C);
        tick();
        bus.i_B_J_result = 2'b00;
        settle();
        check("stale_req1", {31'd0, bus.o_Imem_Req}, 32'd1);
        check("stale_addr1", bus.o_Imem_Addr, 32'h30C);
        tick();
        check("stale_addr2", bus.o_Imem_Addr, 32'h30C);
        bus.i_Imem_Gnt = 1'b1;
        tick();
        bus.i_Imem_Gnt = 1'b0;
        check("stale_drop_req", {31'd0, bus.o_Imem_Req}, 32'd0);
        bus.i_Imem_Rvalid = 1'b1;
        bus.i_Imem_Rdata  = 32'hA000_030C;
        tick();
        bus.i_Imem_Rvalid = 1'b0;
        check("stale_drop_valid", {31'd0, bus.o_Instr_Valid}, 32'd0);
        fetch_one(32'h400);

        // 5. Decode stalls for 5 cycles with the slot full.
        bus.i_Instr_Ready = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("bp_no_req", {31'd0, bus.o_Imem_Req}, 32'd0);
            check("bp_valid", {31'd0, bus.o_Instr_Valid}, 32'd1);
            check("bp_pc", bus.o_Instr_PC, 32'h400);
            check("bp_instr", bus.o_Instr, 32'hA000_0400);
            tick();
        end
        bus.i_Instr_Ready = 1'b1;
        settle();
        fetch_one(32'h404);
        fetch_one(32'h408);

        // 6. Reset asserted while in WAIT; a late response is ignored.
        bus.i_Imem_Gnt = 1'b1;
        tick();
        bus.i_Imem_Gnt      = 1'b0;
        rst                 = 1'b1;
        bus.i_B_J_result    = 2'b01;
        bus.i_Branch_Target = 32'h500;
        settle();
        check("r6_req", {31'd0, bus.o_Imem_Req}, 32'd0);
        check("r6_addr", bus.o_Imem_Addr, RST_PC);
        check("r6_instr", bus.o_Instr, 32'd0);
        check("r6_pc", bus.o_Instr_PC, 32'd0);
        check("r6_valid", {31'd0, bus.o_Instr_Valid}, 32'd0);
        check("r6_flush", {31'd0, bus.o_Flush}, 32'd0);
        bus.i_B_J_result = 2'b00;
        tick();
        rst               = 1'b0;
        bus.i_Imem_Rvalid = 1'b1;
        bus.i_Imem_Rdata  = 32'hDEAD_BEEF;
        settle();
        check("r6_idle_req", {31'd0, bus.o_Imem_Req}, 32'd0);
        tick();
        bus.i_Imem_Rvalid = 1'b0;
        check("r6_late_valid", {31'd0, bus.o_Instr_Valid}, 32'd0);
        check("r6_late_instr", bus.o_Instr, 32'd0);
        fetch_one(32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
